// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 104;

  function automatic logic even_par(
    input logic [DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery handshake between the UART receiver and its consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_byte;

  modport master (
    output rx_valid,
    output rx_byte,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_byte,
    output rx_ready
  );
endinterface

// File: rtl/uart_sync.sv
// Flop-chain synchronizer for asynchronous inputs; resets to 1 (idle line).
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ff <= '1;
    end else begin
      r_ff <= {r_ff[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte delivery.
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      serial_rx,
  uart_rx_if.master rx,
  output logic      overrun,
  output logic      frame_error,
  output logic      parity_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  logic        w_s;
  uart_state_t r_state;
  uart_state_t w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_byte;
  logic        r_valid;
  logic        r_ovr;
  logic        r_fe;
  logic        w_tick;
  logic        w_stop;
  logic        w_done;
  logic        w_xfer;
  logic        w_bad;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (serial_rx),
    .o_q   (w_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_tick = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_s) w_next = START;
      end
      START: begin
        if (r_cnt == HALF) begin
          w_tick = 1'b1;
          w_next = w_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == LAST) begin
          w_tick = 1'b1;
          if (r_bit == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_next = PARITY;
`else
            w_next = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (r_cnt == LAST) begin
          w_tick = 1'b1;
          w_next = STOP;
        end
      end
      STOP: begin
        if (r_cnt == LAST) begin
          w_tick = 1'b1;
          w_next = w_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (w_s) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter restarts on each sample and on every state entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (w_tick || (w_next != r_state) ||
          (r_state == IDLE) ||
          (r_state == BREAK)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state != DATA) begin
        r_bit <= '0;
      end else if (w_tick) begin
        r_bit <= r_bit + 1'b1;
      end
      if ((r_state == DATA) && w_tick) begin
        r_shift <= {w_s, r_shift[7:1]};
      end
    end
  end

  assign w_stop = (r_state == STOP) && w_tick;
  assign w_done = w_stop && w_s && !w_bad;
  assign w_xfer = r_valid && rx.rx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_byte  <= '0;
      r_ovr   <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      r_fe  <= w_stop && !w_s;
      if (w_done) begin
        if (!r_valid || w_xfer) begin
          r_byte  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_pbad;
  logic r_pe;

  // Mismatch is held until the stop sample so framing wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pbad <= 1'b0;
      r_pe   <= 1'b0;
    end else begin
      r_pe <= w_stop && w_s && r_pbad;
      if (r_state == START) begin
        r_pbad <= 1'b0;
      end else if ((r_state == PARITY) && w_tick) begin
        r_pbad <= (w_s != even_par(r_shift));
      end
    end
  end

  assign w_bad        = r_pbad;
  assign parity_error = r_pe;
`else
  assign w_bad        = 1'b0;
  assign parity_error = 1'b0;
`endif

  assign rx.rx_valid  = r_valid;
  assign rx.rx_byte   = r_byte;
  assign overrun      = r_ovr;
  assign frame_error  = r_fe;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel receiver that turns the asynchronous `serial_rx` pin into bytes for the loopback/command logic above it.
- 8N1 framing, LSB first, fixed baud set by parameter.
- Delivers each byte over a valid/ready handshake (`rx_valid`/`rx_ready`/`rx_byte`).
- Flags overrun and framing errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit period (12 MHz / 115200); legal range 4..65535.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer; legal range 2..4.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- serial_rx  input  1  asynchronous UART line; idles high.
- rx_ready  input  1  consumer can accept a byte this cycle.
- rx_valid  output  1  `rx_byte` holds an unconsumed byte.
- rx_byte  output  8  received data.
- overrun  output  1  one-cycle pulse: a completed byte was dropped because the holding register was full.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- parity_error  output  1  one-cycle pulse: parity mismatch (feature only); tied 0 otherwise.

Behaviour:
- Reset
  - Reset is synchronous and active-high on `reset`, sampled at the posedge of `clock`.
  - Outputs: rx_valid=0, rx_byte=0, overrun=0, frame_error=0, parity_error=0.
  - Internal: state=IDLE, bit counter=0, baud counter=0, all synchronizer flops=1.
  - Reset mid-frame abandons the frame; the receiver returns to IDLE and rx_valid drops.
- Input
  - `serial_rx` passes through SYNC_STAGES flops; all logic uses the synchronized value `s`.
- Timing
  - Let H = CLKS_PER_BIT/2 (integer division).
  - Baud counter counts 0..CLKS_PER_BIT-1, resetting on every state entry.
- State machine
  - IDLE: on s==0, go to START with the counter cleared.
  - START: sample s after H cycles.
    - s==1: false start; return to IDLE with no pulse.
    - s==0: go to DATA with bit index 0.
  - DATA: sample every CLKS_PER_BIT cycles; shift into a shift register, LSB first. After bit index 7, go to STOP (or PARITY with the feature).
  - STOP: sample after CLKS_PER_BIT cycles.
    - s==1: byte complete; return to IDLE.
    - s==0: frame_error pulse next cycle, byte discarded, go to BREAK.
  - BREAK: wait for s==1, then go to IDLE. This covers a held-low line without re-triggering.
- Delivery
  - On byte complete, the next cycle has rx_byte=shift register and rx_valid=1.
  - Transfer occurs on a cycle with rx_valid && rx_ready; rx_valid clears the following cycle.
  - rx_byte stays stable while rx_valid=1 and the consumer has not yet accepted it.
  - Transfer in the same cycle a new byte completes: the new byte loads and rx_valid stays 1; no overrun.
  - Byte completes while rx_valid=1 and no transfer that cycle: the old byte is kept, the new byte is dropped, and overrun pulses for 1 cycle.
- Error pulses
  - Never assert simultaneously with each other for the same frame; frame_error takes priority over parity_error.
  - Are independent of the handshake.
- Back-to-back frames
  - A start bit immediately following the stop sample is detected.
  - Reception needs no idle time beyond the second half of the stop bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- With the macro:
  - Adds a PARITY state after DATA that samples one even-parity bit.
  - On mismatch: byte discarded, parity_error pulses with the stop-sample timing, normal STOP handling continues.
  - Frame becomes 8E1.
- Without the macro:
  - 8N1 only, no PARITY state.
  - `parity_error` tied to 0; the port list is unchanged.

Decomposition:
- Shared package `uart_pkg`:
  - state enum {IDLE, START, DATA, PARITY, STOP, BREAK};
  - DATA_BITS=8 constant;
  - default CLKS_PER_BIT constant, reused by the transmitter.
- Sub-module `uart_sync`:
  - parameterized SYNC_STAGES flop chain with reset value 1;
  - reusable for other async inputs.

Test Plan (CLKS_PER_BIT=8):
- Send 0xA5, 8N1, rx_ready=1 -> exactly one rx_valid cycle with rx_byte=0xA5; no error pulses.
- Send 0x3C then 0xC3 back-to-back, rx_ready=0 until both frames are done -> rx_byte stays 0x3C, rx_valid=1, one overrun pulse after the second stop bit; raising rx_ready gives one transfer of 0x3C, then rx_valid=0.
- Hold rx_ready=0, send 0x11, then raise rx_ready exactly in the cycle 0x22 completes -> 0x11 transferred, rx_valid stays 1 with rx_byte=0x22, no overrun.
- Low glitch of 3 cycles on an idle line -> no rx_valid, no error pulses, receiver back in IDLE.
- Send 0x55 with the stop bit driven low, then keep the line low 40 cycles -> frame_error pulses once, no rx_valid; after the line returns high, 0x0F is received correctly.
- Assert reset mid-DATA of a 0xFF frame -> rx_valid=0, outputs at reset values; the next clean 0x81 frame is received correctly.
- With UART_RX_PARITY_EN, send 0x07 with a wrong parity bit -> parity_error pulses once, no rx_valid.
